pipe_f_stage: RTL

Instruction-fetch stage of the five-stage pipeline: owns the program counter, selects the next PC, and drives a ready/request instruction-memory port. It hands `pc4` and `ins` to the IF/ID register downstream. It honours that register's write enable `wpcir` and inserts NOP bubbles (32'h0) while memory is slow. Branches and jumps are resolved in decode with one delay slot; this stage stores any redirect that arrives while its own fetch is still outstanding.

---
 rtl/pipe_f_stage.sv | 105 ++++++++++
 1 files changed

// File: rtl/pipe_f_stage.sv
// pipe_f_stage: instruction-fetch stage. Owns the PC, selects the next PC,
// runs a ready/request instruction-memory port, and feeds pc4/ins to IF/ID.
// A one-entry holding buffer keeps an instruction that arrived while decode
// was stalled. A pending-redirect register keeps a branch/jump target that
// decode resolved while the delay-slot fetch was still waiting on memory.
module pipe_f_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] rpc,
  input  logic [31:0] jpc,
  input  logic        wpcir,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic [31:0] ins,
  output logic        if_busy
);

  logic [31:0] r_pc;
  logic [31:0] r_hbuf;
  logic        r_hvalid;
  logic        r_rpend;
  logic [31:0] r_rtarget;

  logic        w_req;
  logic        w_hit;
  logic        w_avail;
  logic        w_deliver;
  logic [31:0] w_pc4;
  logic [31:0] w_sel;
  logic [31:0] w_npc;

  // The request is dropped while the holding buffer already has the
  // instruction for this PC, and is forced low during reset.
  assign w_req     = resetn & ~r_hvalid;
  assign w_hit     = w_req & imem_ready;
  assign w_avail   = r_hvalid | w_hit;
  assign w_deliver = w_avail & wpcir;
  assign w_pc4     = r_pc + 32'd4;

  assign imem_req  = w_req;
  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign pc4       = w_pc4;
  assign if_busy   = ~w_avail;

  // Instruction to IF/ID: held copy first, then live memory data, else bubble.
  always_comb begin
    ins = 32'h0;
    if (r_hvalid)
      ins = r_hbuf;
    else if (w_hit)
      ins = imem_rdata;
  end

  // Decode's next-PC choice; the adder wraps modulo 2^32 naturally.
  always_comb begin
    w_sel = w_pc4;
    case (pcsource)
      2'b00:   w_sel = w_pc4;
      2'b01:   w_sel = bpc;
      2'b10:   w_sel = rpc;
      default: w_sel = jpc;
    endcase
  end

  // A stored redirect wins over whatever decode presents now (decode is
  // sending a bubble while the delay slot is still being fetched).
  always_comb begin
    w_npc = w_sel;
    if (r_rpend)
      w_npc = r_rtarget;
  end

  // PC, holding buffer and pending-redirect update.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_pc      <= RESET_PC;
      r_hbuf    <= 32'h0;
      r_hvalid  <= 1'b0;
      r_rpend   <= 1'b0;
      r_rtarget <= 32'h0;
    end else if (w_deliver) begin
      r_pc     <= w_npc;
      r_hvalid <= 1'b0;
      r_rpend  <= 1'b0;
    end else if (w_avail && !r_hvalid) begin
      // Decode stalled with the instruction in hand: park it, stop requesting.
      r_hbuf   <= imem_rdata;
      r_hvalid <= 1'b1;
    end else if (!w_avail && wpcir && (pcsource != 2'b00) && !r_rpend) begin
      // Redirect resolved before its delay slot arrived: remember the target.
      r_rpend   <= 1'b1;
      r_rtarget <= w_sel;
    end
  end

endmodule
